ebi_slave_trx: RTL and testbench
================================

EBI_SLAVE_TRX -- requirements
Module: ebi_slave_trx

Interface
REQ-001 Parameters SHALL be: EBI_WIDTH, default 16, bus width; PADDR_WIDTH, default 32, address width; CACHELINE_LENGTH, default 512, line bits.
REQ-002 Ports SHALL be: clk  in  1  sole clock, all logic on posedge; rst  in  1  synchronous active-high reset.
REQ-003 Ports SHALL be: ebi_i  in  16  pad input; ebi_o  out  16  pad output; ebi_oen  out  16  output enable, active-low, all bits equal.
REQ-004 Ports SHALL be: req_valid  out  1  one-cycle pulse, host request decoded; req_opcode  out  4; req_addr  out  32; req_ctrl  out  16  arsnoop/control word; req_data  out  512; rx_err  out  1  one-cycle pulse, malformed frame.
REQ-005 Ports SHALL be: tx_valid  in  1; tx_ready  out  1; tx_opcode  in  4  (6 SNP_REQ, 7 RD_RESP, 15 ACK); tx_addr  in  32; tx_ctrl  in  16  MESI or snoop word; tx_data  in  512; tx_done  out  1  pulse.

Function
REQ-006 Frame SHALL be: start word 16'hFFFE, opcode word (bits[3:0] = opcode, upper bits 1), payload words lowest-first, stop word 16'hFFFF; idle bus SHALL read 16'hFFFF.
REQ-007 Receive payload lengths SHALL be: DR(0) addr2+ctrl1; DW1(1) addr2+ctrl1+data32; DW2(2) addr2+ctrl1; SNP_RESP1(3) data32; SNP_RESP2(4) none.
REQ-008 Transmit payload lengths SHALL be: SNP_REQ(6) addr2+ctrl1; RD_RESP(7) data32+ctrl1; ACK(15) none, i.e. start, opcode, stop.
REQ-009 ebi_i SHALL pass through one synchronizing register (rff) before any decode.
REQ-010 FSM states SHALL be IDLE, RX_OPC, RX_PAY, RX_STOP, TX_START, TX_OPC, TX_PAY, TX_STOP.
REQ-011 IDLE->RX_OPC when rff[0]==0; IDLE->TX_START when tx_valid && tx_ready; receive SHALL win if both occur in one cycle (tx_ready low that cycle).
REQ-012 tx_ready SHALL be high only in IDLE with rff[0]==1.
REQ-013 RX_OPC: opcode 0-4 -> RX_PAY (or RX_STOP if zero payload); other opcode -> IDLE with rx_err pulse next cycle.
REQ-014 RX_PAY SHALL store each word at buffer[16*k +: 16], k = 6-bit word counter from 0, until k reaches payload length, then RX_STOP.
REQ-015 RX_STOP: rff==16'hFFFF -> req_valid pulse next cycle; else rx_err pulse next cycle, no req_valid; both return to IDLE.
REQ-016 Field mapping: addr = words 0-1, ctrl = word 2, data = words 3-34 for DR/DW1/DW2; data = words 0-31 for SNP_RESP1; unused fields SHALL read 0.
REQ-017 req_* fields SHALL hold from req_valid until the next frame's RX_OPC; no backpressure, consumer samples on req_valid.
REQ-018 Transmit: tx_* SHALL be captured on handshake cycle T; ebi_oen = 0 from T+1; start word at T+1, opcode T+2, payload from T+3, stop word last.
REQ-019 tx_done SHALL pulse in the cycle the stop word is driven; ebi_oen SHALL return to all-ones the next cycle; FSM then IDLE.
REQ-020 RD_RESP SHALL occupy 36 bus cycles T+1..T+36; ACK SHALL occupy 3 cycles T+1..T+3.
REQ-021 While ebi_oen is low, receive decode SHALL be ignored; ebi_o SHALL be 16'hFFFF whenever ebi_oen is high.
REQ-022 Word counter SHALL saturate at 63; counter compare width 6 bits.

Reset
REQ-023 rst high at posedge SHALL force IDLE, ebi_oen=all-ones, ebi_o=16'hFFFF, tx_ready=0 that cycle, req_valid=rx_err=tx_done=0, req_* = 0, counter=0.
REQ-024 Reset mid-frame SHALL abort the frame without any req_valid, rx_err or tx_done pulse.

Structure
REQ-025 Opcode values, per-opcode word counts, start/stop/idle words SHALL live in a shared ebi package used by both bus ends.
REQ-026 Input synchronizer SHALL be a separate sub-module ebi_sync_reg (EBI_WIDTH-wide register, reset to all-ones).

Verification
REQ-027 DR frame FFFE,FFF0,1234,ABCD,0003,FFFF on ebi_i -> req_valid once, req_addr=32'hABCD1234, req_ctrl=16'h0003.
REQ-028 tx_opcode=7, tx_data=incrementing words, tx_ctrl=0002 -> 36 driven cycles, data words in order, tx_done with FFFF, oen high after.
REQ-029 Start word arriving same cycle tx_valid=1 -> receive completes first, transmit starts after return to IDLE.
REQ-030 Frame with opcode 9 -> rx_err pulse, no req_valid; DR frame with stop word 0000 -> rx_err, no req_valid.
REQ-031 rst asserted at DW1 payload word 10 -> all outputs at reset values, subsequent DW2 frame decodes correctly.
REQ-032 tx_opcode=15 -> ebi_o FFFE, FFFF, FFFF over 3 cycles, tx_done on third.

Source files
------------

// File: rtl/ebi_pkg.sv
// Shared EBI bus definitions used by both ends of the link: frame
// delimiter words, opcode values, per-opcode payload word counts and the
// slave transceiver state encoding.
package ebi_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [WORD_W-1:0] WORD_START = 16'hFFFE;
  localparam logic [WORD_W-1:0] WORD_STOP  = 16'hFFFF;
  localparam logic [WORD_W-1:0] WORD_IDLE  = 16'hFFFF;

  localparam int unsigned ADDR_WORDS   = 2;
  localparam int unsigned CTRL_WORDS   = 1;
  localparam int unsigned DATA_WORDS   = 32;
  localparam int unsigned RX_MAX_WORDS = ADDR_WORDS + CTRL_WORDS + DATA_WORDS;
  localparam int unsigned TX_MAX_WORDS = DATA_WORDS + CTRL_WORDS;

  typedef enum logic [3:0] {
    OP_DR        = 4'd0,
    OP_DW1       = 4'd1,
    OP_DW2       = 4'd2,
    OP_SNP_RESP1 = 4'd3,
    OP_SNP_RESP2 = 4'd4,
    OP_SNP_REQ   = 4'd6,
    OP_RD_RESP   = 4'd7,
    OP_ACK       = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_OPC,
    ST_RX_PAY,
    ST_RX_STOP,
    ST_TX_START,
    ST_TX_OPC,
    ST_TX_PAY,
    ST_TX_STOP
  } state_e;

  // Host-to-slave opcodes are the contiguous range 0..4.
  function automatic logic rx_opcode_ok(input logic [3:0] opc);
    return opc <= OP_SNP_RESP2;
  endfunction

  function automatic logic [5:0] rx_pay_len(input logic [3:0] opc);
    case (opc)
      OP_DR, OP_DW2: return 6'(ADDR_WORDS + CTRL_WORDS);
      OP_DW1:        return 6'(RX_MAX_WORDS);
      OP_SNP_RESP1:  return 6'(DATA_WORDS);
      default:       return 6'd0;
    endcase
  endfunction

  function automatic logic [5:0] tx_pay_len(input logic [3:0] opc);
    case (opc)
      OP_SNP_REQ: return 6'(ADDR_WORDS + CTRL_WORDS);
      OP_RD_RESP: return 6'(TX_MAX_WORDS);
      default:    return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/ebi_sync_reg.sv
// Input synchronizing register for the EBI pad bus.
// Ports: clk, rst (sync, active-high), d (pad input), q (registered copy,
// resets to all-ones so an idle bus is seen while in reset).
module ebi_sync_reg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= '1;
    else     q <= d;
  end

endmodule

// File: rtl/ebi_slave_trx.sv
// EBI slave transceiver: decodes host frames arriving on ebi_i into
// req_* pulses and serialises local tx_* transactions onto ebi_o.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   ebi_i/ebi_o/ebi_oen- pad in, pad out, active-low output enable
//   req_*              - decoded host request, qualified by req_valid
//   rx_err             - one-cycle pulse on a malformed frame
//   tx_valid/tx_ready  - transmit handshake; tx_* captured on handshake
//   tx_done            - pulses while the stop word is on the bus
module ebi_slave_trx
  import ebi_pkg::*;
#(
  parameter int unsigned EBI_WIDTH        = 16,
  parameter int unsigned PADDR_WIDTH      = 32,
  parameter int unsigned CACHELINE_LENGTH = 512
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [EBI_WIDTH-1:0]        ebi_i,
  output logic [EBI_WIDTH-1:0]        ebi_o,
  output logic [EBI_WIDTH-1:0]        ebi_oen,
  output logic                        req_valid,
  output logic [3:0]                  req_opcode,
  output logic [PADDR_WIDTH-1:0]      req_addr,
  output logic [EBI_WIDTH-1:0]        req_ctrl,
  output logic [CACHELINE_LENGTH-1:0] req_data,
  output logic                        rx_err,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic [3:0]                  tx_opcode,
  input  logic [PADDR_WIDTH-1:0]      tx_addr,
  input  logic [EBI_WIDTH-1:0]        tx_ctrl,
  input  logic [CACHELINE_LENGTH-1:0] tx_data,
  output logic                        tx_done
);

  localparam int unsigned RX_BUF_W = PADDR_WIDTH + EBI_WIDTH + CACHELINE_LENGTH;
  localparam int unsigned RX_WORDS = RX_BUF_W / EBI_WIDTH;
  localparam int unsigned TX_BUF_W = CACHELINE_LENGTH + EBI_WIDTH;

  logic [EBI_WIDTH-1:0] rff;
  state_e               state_q, state_d;
  logic [5:0]           cnt_q, cnt_inc;
  logic [3:0]           rx_opc_q, tx_opc_q;
  logic [RX_BUF_W-1:0]  rx_buf_q;
  logic [TX_BUF_W-1:0]  tx_buf_q;

  ebi_sync_reg #(.WIDTH(EBI_WIDTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ebi_i),
    .q   (rff)
  );

  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 6'd1;

  // A start word already in rff blocks the handshake, so receive wins.
  assign tx_ready = (state_q == ST_IDLE) && rff[0] && !rst;

  always_comb begin
    state_d = state_q;
    tx_done = 1'b0;
    ebi_oen = '1;
    ebi_o   = '1;
    unique case (state_q)
      ST_IDLE: begin
        if (!rff[0])                    state_d = ST_RX_OPC;
        else if (tx_valid && tx_ready)  state_d = ST_TX_START;
      end
      ST_RX_OPC: begin
        if (!rx_opcode_ok(rff[3:0]))         state_d = ST_IDLE;
        else if (rx_pay_len(rff[3:0]) == '0) state_d = ST_RX_STOP;
        else                                 state_d = ST_RX_PAY;
      end
      ST_RX_PAY: begin
        if (cnt_inc == rx_pay_len(rx_opc_q)) state_d = ST_RX_STOP;
      end
      ST_RX_STOP: state_d = ST_IDLE;
      ST_TX_START: begin
        ebi_oen = '0;
        ebi_o   = WORD_START;
        state_d = ST_TX_OPC;
      end
      ST_TX_OPC: begin
        ebi_oen = '0;
        ebi_o   = {{(EBI_WIDTH-4){1'b1}}, tx_opc_q};
        state_d = (tx_pay_len(tx_opc_q) == '0) ? ST_TX_STOP : ST_TX_PAY;
      end
      ST_TX_PAY: begin
        ebi_oen = '0;
        ebi_o   = tx_buf_q[EBI_WIDTH-1:0];
        if (cnt_inc == tx_pay_len(tx_opc_q)) state_d = ST_TX_STOP;
      end
      ST_TX_STOP: begin
        ebi_oen = '0;
        ebi_o   = WORD_STOP;
        tx_done = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rx_opc_q   <= '0;
      tx_opc_q   <= '0;
      rx_buf_q   <= '0;
      tx_buf_q   <= '0;
      req_valid  <= 1'b0;
      rx_err     <= 1'b0;
      req_opcode <= '0;
      req_addr   <= '0;
      req_ctrl   <= '0;
      req_data   <= '0;
    end else begin
      state_q   <= state_d;
      req_valid <= 1'b0;
      rx_err    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (tx_valid && tx_ready) begin
            tx_opc_q <= tx_opcode;
            // Payload is laid out lowest-word-first so TX_PAY only shifts.
            case (tx_opcode)
              OP_SNP_REQ: tx_buf_q <= TX_BUF_W'({tx_ctrl, tx_addr});
              OP_RD_RESP: tx_buf_q <= {tx_ctrl, tx_data};
              default:    tx_buf_q <= '0;
            endcase
          end
        end
        ST_RX_OPC: begin
          cnt_q <= '0;
          // Cleared per frame so fields an opcode does not carry read 0.
          rx_buf_q <= '0;
          if (rx_opcode_ok(rff[3:0])) rx_opc_q <= rff[3:0];
          else                        rx_err   <= 1'b1;
        end
        ST_RX_PAY: begin
          for (int unsigned i = 0; i < RX_WORDS; i++) begin
            if (cnt_q == 6'(i)) rx_buf_q[i*EBI_WIDTH +: EBI_WIDTH] <= rff;
          end
          cnt_q <= cnt_inc;
        end
        ST_RX_STOP: begin
          if (rff == WORD_STOP) begin
            req_valid  <= 1'b1;
            req_opcode <= rx_opc_q;
            if (rx_opc_q == OP_SNP_RESP1) begin
              req_addr <= '0;
              req_ctrl <= '0;
              req_data <= rx_buf_q[0 +: CACHELINE_LENGTH];
            end else if (rx_opc_q == OP_SNP_RESP2) begin
              req_addr <= '0;
              req_ctrl <= '0;
              req_data <= '0;
            end else begin
              req_addr <= rx_buf_q[0 +: PADDR_WIDTH];
              req_ctrl <= rx_buf_q[PADDR_WIDTH +: EBI_WIDTH];
              req_data <= rx_buf_q[PADDR_WIDTH+EBI_WIDTH +: CACHELINE_LENGTH];
            end
          end else begin
            rx_err <= 1'b1;
          end
        end
        ST_TX_OPC: cnt_q <= '0;
        ST_TX_PAY: begin
          tx_buf_q <= tx_buf_q >> EBI_WIDTH;
          cnt_q    <= cnt_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ebi_slave_trx.sv
// Scoreboard bench for ebi_slave_trx: stimulus pushes expected host
// requests / bus words, an independent monitor pops and compares them.
module tb_ebi_slave_trx;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  ebi_i = 16'hFFFF;
  logic [15:0]  ebi_o, ebi_oen;
  logic         req_valid, rx_err, tx_ready, tx_done;
  logic [3:0]   req_opcode;
  logic [31:0]  req_addr;
  logic [15:0]  req_ctrl;
  logic [511:0] req_data;
  logic         tx_valid = 1'b0;
  logic [3:0]   tx_opcode = '0;
  logic [31:0]  tx_addr = '0;
  logic [15:0]  tx_ctrl = '0;
  logic [511:0] tx_data = '0;

  typedef logic [15:0] word_q_t[$];
  typedef struct {
    bit           err;
    logic [3:0]   op;
    logic [31:0]  addr;
    logic [15:0]  ctrl;
    logic [511:0] data;
  } rx_exp_t;
  typedef struct {
    logic [15:0] w;
    bit          last;
  } tx_exp_t;

  rx_exp_t rx_q[$];
  tx_exp_t tx_q[$];
  int      checks = 0;
  int      errors = 0;
  bit      prev_done = 1'b0;
  rx_exp_t mon_r;
  tx_exp_t mon_t;

  ebi_slave_trx #(.EBI_WIDTH(16), .PADDR_WIDTH(32), .CACHELINE_LENGTH(512)) dut (
    .clk(clk), .rst(rst), .ebi_i(ebi_i), .ebi_o(ebi_o), .ebi_oen(ebi_oen),
    .req_valid(req_valid), .req_opcode(req_opcode), .req_addr(req_addr),
    .req_ctrl(req_ctrl), .req_data(req_data), .rx_err(rx_err),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_opcode(tx_opcode),
    .tx_addr(tx_addr), .tx_ctrl(tx_ctrl), .tx_data(tx_data), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int rx_len(input logic [3:0] op);
    case (op)
      4'd0, 4'd2: return 3;
      4'd1:       return 35;
      4'd3:       return 32;
      default:    return 0;
    endcase
  endfunction

  function automatic word_q_t rand_words(input int n);
    word_q_t q;
    for (int i = 0; i < n; i++) q.push_back(16'($urandom));
    return q;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  function automatic rx_exp_t model_rx(input logic [3:0] op, input word_q_t p, input bit stop_ok);
    rx_exp_t e;
    e.err  = (op > 4'd4) || !stop_ok;
    e.op   = op;
    e.addr = '0;
    e.ctrl = '0;
    e.data = '0;
    if (op <= 4'd2) begin
      e.addr = {p[1], p[0]};
      e.ctrl = p[2];
      if (op == 4'd1)
        for (int i = 0; i < 32; i++) e.data[16*i +: 16] = p[3+i];
    end else if (op == 4'd3) begin
      for (int i = 0; i < 32; i++) e.data[16*i +: 16] = p[i];
    end
    return e;
  endfunction

  function automatic word_q_t model_tx(input logic [3:0] op, input logic [31:0] addr,
                                       input logic [15:0] ctrl, input logic [511:0] data);
    word_q_t q;
    q.push_back(16'hFFFE);
    q.push_back({12'hFFF, op});
    if (op == 4'd6) begin
      q.push_back(addr[15:0]);
      q.push_back(addr[31:16]);
      q.push_back(ctrl);
    end else if (op == 4'd7) begin
      for (int i = 0; i < 32; i++) q.push_back(data[16*i +: 16]);
      q.push_back(ctrl);
    end
    q.push_back(16'hFFFF);
    return q;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    chk("oen_uniform", 512'(ebi_oen == 16'h0000 || ebi_oen == 16'hFFFF), 512'(1));
    if (prev_done) chk("oen_after_done", 512'(ebi_oen), 512'(16'hFFFF));
    if (ebi_oen != 16'h0000) begin
      chk("idle_ebi_o", 512'(ebi_o), 512'(16'hFFFF));
      chk("idle_tx_done", 512'(tx_done), 512'(0));
    end else if (tx_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_tx: ebi_o=%h driven with no word expected", ebi_o);
    end else begin
      mon_t = tx_q.pop_front();
      chk("tx_word", 512'(ebi_o), 512'(mon_t.w));
      chk("tx_done", 512'(tx_done), 512'(mon_t.last));
    end
    prev_done = tx_done;
    if (req_valid || rx_err) begin
      if (rx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rx: req_valid=%b rx_err=%b with nothing expected", req_valid, rx_err);
      end else begin
        mon_r = rx_q.pop_front();
        chk("rx_err", 512'(rx_err), 512'(mon_r.err));
        chk("req_valid", 512'(req_valid), 512'(!mon_r.err));
        if (!mon_r.err) begin
          chk("req_opcode", 512'(req_opcode), 512'(mon_r.op));
          chk("req_addr", 512'(req_addr), 512'(mon_r.addr));
          chk("req_ctrl", 512'(req_ctrl), 512'(mon_r.ctrl));
          chk("req_data", req_data, mon_r.data);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // All tasks are entered just after a falling edge.
  task automatic send_frame(input word_q_t w);
    foreach (w[i]) begin
      ebi_i = w[i];
      @(negedge clk);
    end
    ebi_i = 16'hFFFF;
  endtask

  task automatic rx_frame(input logic [3:0] op, input word_q_t p, input logic [15:0] stop);
    word_q_t w;
    w.push_back(16'hFFFE);
    w.push_back({12'hFFF, op});
    if (op <= 4'd4) foreach (p[i]) w.push_back(p[i]);
    w.push_back(stop);
    rx_q.push_back(model_rx(op, p, stop == 16'hFFFF));
    send_frame(w);
  endtask

  task automatic do_tx(input logic [3:0] op, input logic [31:0] addr, input logic [15:0] ctrl,
                       input logic [511:0] data, input bit noise, input bit order);
    word_q_t w;
    tx_exp_t t;
    int n;
    w = model_tx(op, addr, ctrl, data);
    foreach (w[i]) begin
      t.w = w[i];
      t.last = (i == w.size() - 1);
      tx_q.push_back(t);
    end
    tx_opcode = op;
    tx_addr   = addr;
    tx_ctrl   = ctrl;
    tx_data   = data;
    tx_valid  = 1'b1;
    n = 0;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      checks++;
      errors++;
      $display("FAIL tx_handshake: tx_ready never rose within %0d cycles", n);
      tx_valid = 1'b0;
      tx_q.delete();
      return;
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_addr  = $urandom;
    tx_ctrl  = 16'($urandom);
    tx_data  = rand_line();
    tx_opcode = 4'($urandom);
    for (int i = 1; i <= w.size(); i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("tx_start_latency", 512'(ebi_oen), 512'(16'h0000));
        if (order) chk("rx_before_tx", 512'(rx_q.size()), 512'(0));
      end
      if (noise) ebi_i = (i < w.size()) ? (16'($urandom) & 16'hFFFE) : 16'hFFFF;
    end
    @(negedge clk);
    chk("tx_oen_release", 512'(ebi_oen), 512'(16'hFFFF));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rx_q.size() != 0 || tx_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rx_q.size() != 0 || tx_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d rx and %0d tx responses never appeared", rx_q.size(), tx_q.size());
      rx_q.delete();
      tx_q.delete();
    end
  endtask

  task automatic check_reset_state();
    chk("rst_req_valid", 512'(req_valid), 512'(0));
    chk("rst_rx_err", 512'(rx_err), 512'(0));
    chk("rst_tx_done", 512'(tx_done), 512'(0));
    chk("rst_tx_ready", 512'(tx_ready), 512'(0));
    chk("rst_ebi_oen", 512'(ebi_oen), 512'(16'hFFFF));
    chk("rst_ebi_o", 512'(ebi_o), 512'(16'hFFFF));
    chk("rst_req_opcode", 512'(req_opcode), 512'(0));
    chk("rst_req_addr", 512'(req_addr), 512'(0));
    chk("rst_req_ctrl", 512'(req_ctrl), 512'(0));
    chk("rst_req_data", req_data, 512'(0));
  endtask

  initial begin
    word_q_t      p, w, empty;
    logic [511:0] d;
    logic [3:0]   op, top;
    int           sel;

    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    @(negedge clk);

    // DR frame with fixed words
    p = '{16'h1234, 16'hABCD, 16'h0003};
    rx_frame(4'd0, p, 16'hFFFF);
    drain();
    chk("dr_addr_literal", 512'(req_addr), 512'(32'hABCD1234));
    chk("dr_ctrl_literal", 512'(req_ctrl), 512'(16'h0003));

    // RD_RESP with incrementing data words
    for (int i = 0; i < 32; i++) d[16*i +: 16] = 16'(i + 1);
    do_tx(4'd7, 32'h0, 16'h0002, d, 1'b0, 1'b0);
    drain();

    // ACK: start, opcode (all ones), stop
    do_tx(4'd15, 32'h0, 16'h0, '0, 1'b0, 1'b0);
    drain();

    // Malformed frames: bad opcode, bad stop word
    rx_frame(4'd9, empty, 16'hFFFF);
    drain();
    p = '{16'h1111, 16'h2222, 16'h3333};
    rx_frame(4'd0, p, 16'h0000);
    drain();

    // Start word and tx_valid coincide: receive completes first
    p = rand_words(35);
    fork
      rx_frame(4'd1, p, 16'hFFFF);
      begin
        @(negedge clk);
        chk("rx_wins_ready", 512'(tx_ready), 512'(0));
        do_tx(4'd6, 32'hCAFE_F00D, 16'h0005, '0, 1'b0, 1'b1);
      end
    join
    drain();

    // Reset during DW1 payload word 10, then a clean DW2 frame
    p = rand_words(35);
    w = '{16'hFFFE, 16'hFFF1};
    for (int i = 0; i <= 10; i++) w.push_back(p[i]);
    send_frame(w);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    p = rand_words(3);
    rx_frame(4'd2, p, 16'hFFFF);
    drain();

    // Randomised mix
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 5);
      case ($urandom_range(0, 2))
        0:       top = 4'd6;
        1:       top = 4'd7;
        default: top = 4'd15;
      endcase
      op = 4'($urandom_range(0, 4));
      p  = rand_words(rx_len(op));
      case (sel)
        0, 1: rx_frame(op, p,
                       ($urandom_range(0, 5) == 0) ? (16'($urandom) & 16'h7FFF) : 16'hFFFF);
        2:    rx_frame(4'($urandom_range(5, 15)), empty, 16'hFFFF);
        3, 4: do_tx(top, $urandom, 16'($urandom), rand_line(), 1'($urandom_range(0, 1)), 1'b0);
        default: begin
          fork
            rx_frame(op, p, 16'hFFFF);
            begin
              @(negedge clk);
              chk("rx_wins_ready", 512'(tx_ready), 512'(0));
              do_tx(top, $urandom, 16'($urandom), rand_line(), 1'b0, 1'b1);
            end
          join
        end
      endcase
      drain();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
